// File: rtl/aes_bram_stream_ctrl_if.sv
// Bus bundle for the AES BRAM stream sequencer.
// Optional capture_count member when AES_STREAM_CAPTURE_CNT_EN is defined.
interface aes_bram_stream_ctrl_if #(
  parameter int LANES  = 5,
  parameter int LANE_W = 128,
  parameter int ADDR_W = 8
);
  logic                    start;
  logic                    mode_wrap;
  logic                    halt;
  logic                    bram_en;
  logic [ADDR_W-1:0]       bram_addr;
  logic [LANES*LANE_W-1:0] lane_out;
  logic [LANES*LANE_W-1:0] result;
  logic                    result_valid;
  logic [ADDR_W-1:0]       result_addr;
  logic                    busy;
  logic                    done;
`ifdef AES_STREAM_CAPTURE_CNT_EN
  logic [15:0]             capture_count;

  modport master (
    input  start, mode_wrap, halt, lane_out,
    output bram_en, bram_addr, result,
    output result_valid, result_addr,
    output busy, done, capture_count
  );

  modport slave (
    output start, mode_wrap, halt, lane_out,
    input  bram_en, bram_addr, result,
    input  result_valid, result_addr,
    input  busy, done, capture_count
  );
`else
  modport master (
    input  start, mode_wrap, halt, lane_out,
    output bram_en, bram_addr, result,
    output result_valid, result_addr,
    output busy, done
  );

  modport slave (
    output start, mode_wrap, halt, lane_out,
    input  bram_en, bram_addr, result,
    input  result_valid, result_addr,
    input  busy, done
  );
`endif
endinterface

// File: rtl/aes_bram_stream_ctrl.sv
// Sweeps a BRAM range, dwells per address, captures AES lane outputs.
// AES_STREAM_CAPTURE_CNT_EN adds a saturating 16-bit capture counter.
module aes_bram_stream_ctrl #(
  parameter int LANES     = 5,
  parameter int LANE_W    = 128,
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 55,
  parameter int BRAM_LAT  = 1,
  parameter int SETTLE    = 4
) (
  input  logic clk,
  input  logic rst_n,
  aes_bram_stream_ctrl_if.master bus
);

  localparam int DW = LANES * LANE_W;
  localparam int CW = $clog2(SETTLE + 1);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(LAST_ADDR);
  localparam logic [CW-1:0] CMAX =
    CW'(SETTLE);

  if (SETTLE < BRAM_LAT + 1) begin : g_bad_settle
    $error("SETTLE must be >= BRAM_LAT+1");
  end

  if (longint'(LAST_ADDR) >=
      (longint'(1) << ADDR_W)) begin : g_bad_last
    $error("LAST_ADDR must be < 2**ADDR_W");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              wrap_q;
  logic              accept;
  logic              advance;
  logic              cap;
  logic              last;
  logic              fin;

  logic [DW-1:0]     result_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              rvalid_q;
  logic              done_q;

  assign last = (addr_q == LAST);
  assign fin  = cap && last && !wrap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // halt outranks the capture: the dwell simply stalls
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.halt) begin
          if (cnt_q == CMAX) begin
            cap = 1'b1;
            if (last && !wrap_q) begin
              state_d = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    unique case (1'b1)
      accept:                 addr_d = '0;
      cap && !last:           addr_d = addr_q + 1'b1;
      cap && last && wrap_q:  addr_d = '0;
      default:                addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      wrap_q   <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      raddr_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      rvalid_q <= cap;
      done_q   <= fin;
      if (accept) begin
        wrap_q <= bus.mode_wrap;
      end
      if (accept || cap) begin
        cnt_q <= '0;
      end else if (advance) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (cap) begin
        raddr_q <= addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (cap) begin
      result_q <= bus.lane_out;
    end
  end

`ifdef AES_STREAM_CAPTURE_CNT_EN
  logic [15:0] cc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= '0;
    end else if (accept) begin
      cc_q <= '0;
    end else if (cap && cc_q != 16'hFFFF) begin
      cc_q <= cc_q + 16'd1;
    end
  end

  assign bus.capture_count = cc_q;
`endif

  assign bus.bram_en      = (state_q == RUN);
  assign bus.busy         = (state_q == RUN);
  assign bus.bram_addr    = addr_q;
  assign bus.result       = result_q;
  assign bus.result_addr  = raddr_q;
  assign bus.result_valid = rvalid_q;
  assign bus.done         = done_q;

endmodule
